fma_dot_sequencer: RTL and testbench
====================================

Name: fma_dot_sequencer

Overview:
Control and operand stage directly upstream of the fused multiply-add unit in the matrix processor. Accepts one dot-product job: a seed plus a length, then an element-pair stream over valid/ready. Drives the FMA operand, seed, updateAccumulator and en inputs, and captures the final accumulator value. Returns the result on a valid/ready output. One job in flight at a time.

Parameters:
WIDTH, 32, operand/accumulator width; must equal the downstream FMA WIDTH
MAX_LEN, 16, maximum vector length per job
CNT_W, 5, width of len and the element counter; must satisfy 2^CNT_W > MAX_LEN

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  job request pulse; sampled only in IDLE
len  in  CNT_W  element count for the job; sampled with start
seed  in  WIDTH  signed accumulator initial value; sampled with start
busy  out  1  high whenever state != IDLE
in_valid  in  1  element pair valid
in_ready  out  1  sequencer can accept an element pair
in_a  in  WIDTH  signed element A
in_b  in  WIDTH  signed element B
fma_a  out  WIDTH  to FMA a
fma_b  out  WIDTH  to FMA b
fma_seed  out  WIDTH  to FMA seed
fma_update_acc  out  1  to FMA updateAccumulator
fma_en  out  1  to FMA en
fma_acc_out  in  WIDTH  from FMA accumulatorOut (combinational sum of current cycle)
res_valid  out  1  result valid
res_ready  in  1  result consumer ready
res_data  out  WIDTH  signed dot-product result

Behaviour:
- Reset (async assert, sync release): state=IDLE, count=0, len_q=0, seed_q=0, res_data=0, res_valid=0, busy=0, in_ready=0, fma_en=0, fma_update_acc=0.
- States: IDLE, RUN, HOLD.
- IDLE:
  - On start with len!=0: latch len_q=len and seed_q=seed, set count=0, go to RUN.
  - On start with len==0: res_data<=seed, go to HOLD. The FMA is never enabled.
  - len > MAX_LEN is clamped to MAX_LEN.
- RUN:
  - in_ready=1.
  - Handshake = in_valid & in_ready.
  - fma_a=in_a and fma_b=in_b (combinational pass-through). fma_seed=seed_q.
  - fma_en=handshake. fma_update_acc = handshake & (count==0), so the first pair sums onto seed_q rather than stale accumulator contents.
  - Each handshake increments count.
  - On the handshake where count==len_q-1: res_data<=fma_acc_out (same cycle, zero added latency), count<=0, go to HOLD.
  - in_valid low means a stall: fma_en=0 and the FMA accumulator holds.
- HOLD:
  - res_valid=1 and in_ready=0. res_data is stable until accepted.
  - On res_ready: go to IDLE. The next start is accepted no earlier than the following cycle.
- start outside IDLE is ignored. No queuing.
- Arithmetic: two's-complement, wraps modulo 2^WIDTH exactly as the FMA does. No saturation.
- Latency: result is valid one cycle after the last element handshake. A len=N job with no stalls takes N+1 cycles from the cycle after start to res_valid.
- Reset mid-job: all state is abandoned immediately and no partial result is emitted. The FMA accumulator is cleared by its own reset.
- fma_a/fma_b when not in RUN: driven to 0.

Optional Feature:
Macro FMA_SEQ_STALL_CNT_EN.
- Defined: adds output port stall_cycles [15:0], which counts RUN cycles with in_valid=0.
  - Clears to 0 on each accepted start.
  - Saturates at 16'hFFFF.
  - Holds its value through HOLD and IDLE.
  - Reset value 0.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- seed=10, len=3, pairs (2,3),(4,5),(-1,6) with no stalls -> res_valid one cycle after the third handshake, res_data=10+6+20-6=30; fma_update_acc high only on the first handshake.
- len=0, seed=-7 -> HOLD the cycle after start, res_data=-7, fma_en never asserts.
- seed=0, len=2, in_valid low for 3 cycles between pairs (1,1),(2,2) -> res_data=5; fma_en low during the stall; stall_cycles=3 when the macro is defined.
- Result held with res_ready=0 for 4 cycles while start pulses -> res_data stable, start ignored; res_ready=1 -> IDLE next cycle, busy=0.
- Back-to-back jobs: job1 seed=100, len=1, (3,3) -> 109; job2 seed=0, len=1, (2,2) -> 4 (no carry-over, confirming update_acc reseed).
- rst_n asserted asynchronously mid-RUN after 2 of 4 pairs -> outputs return to reset values without a clock edge; a new job afterwards with seed=1, len=1, (1,1) -> 2.

Source files
------------

// File: rtl/fma_dot_sequencer.sv
// Operand/control sequencer feeding the fused multiply-add unit for one dot-product job.
// Optional stall cycle counter port enabled by defining FMA_SEQ_STALL_CNT_EN.
module fma_dot_sequencer #(
   parameter int WIDTH   = 32,
   parameter int MAX_LEN = 16,
   parameter int CNT_W   = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] len,
   input  logic [WIDTH-1:0] seed,
   output logic             busy,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic [WIDTH-1:0] fma_a,
   output logic [WIDTH-1:0] fma_b,
   output logic [WIDTH-1:0] fma_seed,
   output logic             fma_update_acc,
   output logic             fma_en,
   input  logic [WIDTH-1:0] fma_acc_out,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data
`ifdef FMA_SEQ_STALL_CNT_EN
   ,
   output logic [15:0]      stall_cycles
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] MAX_LEN_C = CNT_W'(MAX_LEN);

   state_t           state_r;
   logic [CNT_W-1:0] count_r;
   logic [CNT_W-1:0] len_q;
   logic [WIDTH-1:0] seed_q;
   logic [CNT_W-1:0] len_clamped_s;
   logic             handshake_s;

   // in_ready is registered and equals (state_r == RUN), so it doubles as the RUN decode.
   assign handshake_s   = in_valid & in_ready;
   assign len_clamped_s = (len > MAX_LEN_C) ? MAX_LEN_C : len;

   // Combinational FMA drive: operands pass straight through only while RUN.
   always_comb begin
      fma_a          = {WIDTH{1'b0}};
      fma_b          = {WIDTH{1'b0}};
      fma_seed       = seed_q;
      fma_en         = handshake_s;
      fma_update_acc = 1'b0;
      if (in_ready) begin
         fma_a          = in_a;
         fma_b          = in_b;
         fma_update_acc = handshake_s & (count_r == CNT_ZERO);
      end else begin
         fma_a          = {WIDTH{1'b0}};
         fma_b          = {WIDTH{1'b0}};
         fma_update_acc = 1'b0;
      end
   end

   // Job FSM with registered status outputs and result capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= IDLE;
         count_r   <= CNT_ZERO;
         len_q     <= CNT_ZERO;
         seed_q    <= {WIDTH{1'b0}};
         res_data  <= {WIDTH{1'b0}};
         res_valid <= 1'b0;
         busy      <= 1'b0;
         in_ready  <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (start) begin
                  busy <= 1'b1;
                  if (len == CNT_ZERO) begin
                     res_data  <= seed;
                     res_valid <= 1'b1;
                     state_r   <= HOLD;
                  end else begin
                     len_q    <= len_clamped_s;
                     seed_q   <= seed;
                     count_r  <= CNT_ZERO;
                     in_ready <= 1'b1;
                     state_r  <= RUN;
                  end
               end
            end
            RUN: begin
               if (handshake_s) begin
                  if (count_r == len_q - CNT_ONE) begin
                     res_data  <= fma_acc_out;
                     count_r   <= CNT_ZERO;
                     in_ready  <= 1'b0;
                     res_valid <= 1'b1;
                     state_r   <= HOLD;
                  end else begin
                     count_r <= count_r + CNT_ONE;
                  end
               end
            end
            HOLD: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  busy      <= 1'b0;
                  state_r   <= IDLE;
               end
            end
            default: begin
               state_r   <= IDLE;
               count_r   <= CNT_ZERO;
               res_valid <= 1'b0;
               busy      <= 1'b0;
               in_ready  <= 1'b0;
            end
         endcase
      end
   end

`ifdef FMA_SEQ_STALL_CNT_EN
   // Saturating count of RUN cycles without input, cleared on each accepted start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles <= 16'd0;
      end else if ((state_r == IDLE) && start) begin
         stall_cycles <= 16'd0;
      end else if (in_ready && !in_valid && (stall_cycles != 16'hFFFF)) begin
         stall_cycles <= stall_cycles + 16'd1;
      end else begin
         stall_cycles <= stall_cycles;
      end
   end
`endif

endmodule

// File: tb/tb_fma_dot_sequencer.sv
// Scoreboard bench for fma_dot_sequencer with a behavioural model of the downstream FMA.
module tb_fma_dot_sequencer;
   localparam int WIDTH = 32;
   localparam int CNT_W = 5;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [CNT_W-1:0] len = '0;
   logic [WIDTH-1:0] seed = '0;
   logic             busy;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] in_a = '0;
   logic [WIDTH-1:0] in_b = '0;
   logic [WIDTH-1:0] fma_a, fma_b, fma_seed;
   logic             fma_update_acc, fma_en;
   logic [WIDTH-1:0] fma_acc_out;
   logic             res_valid;
   logic             res_ready = 1'b1;
   logic [WIDTH-1:0] res_data;
`ifdef FMA_SEQ_STALL_CNT_EN
   logic [15:0]      stall_cycles;
`endif

   int n_checks = 0;
   int n_pass   = 0;
   logic [WIDTH-1:0] exp_q[$];
   logic [WIDTH-1:0] acc_r;
   logic             en_seen;

   fma_dot_sequencer #(.WIDTH(WIDTH), .MAX_LEN(16), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .len(len), .seed(seed), .busy(busy),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .fma_a(fma_a), .fma_b(fma_b), .fma_seed(fma_seed),
      .fma_update_acc(fma_update_acc), .fma_en(fma_en), .fma_acc_out(fma_acc_out),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
`ifdef FMA_SEQ_STALL_CNT_EN
      , .stall_cycles(stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   // Downstream FMA: combinational sum this cycle, accumulator updated on enabled edges.
   always_comb begin
      if (fma_en) fma_acc_out = (fma_update_acc ? fma_seed : acc_r) + fma_a * fma_b;
      else        fma_acc_out = acc_r;
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)      acc_r <= '0;
      else if (fma_en) acc_r <= fma_acc_out;
   end

   always @(posedge clk) if (fma_en) en_seen = 1'b1;

   task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h)", name, $signed(act), act, $signed(exp), exp);
   endtask

   // Monitor: every accepted result is popped and compared against the scoreboard.
   always @(negedge clk) begin
      #2;
      if (rst_n && res_valid && res_ready) begin
         if (exp_q.size() == 0) check("unexpected_result", res_data, 32'hDEAD_BEEF);
         else check("result", res_data, exp_q.pop_front());
      end
   end

   // Called at a negedge; returns at the negedge after the start pulse.
   task automatic start_job(input logic [WIDTH-1:0] s, input int n, input bit expect_result,
                            input logic [WIDTH-1:0] exp);
      if (expect_result) exp_q.push_back(exp);
      start = 1'b1; len = CNT_W'(n); seed = s;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic pair(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic upd);
      in_valid = 1'b1; in_a = a; in_b = b;
      #1;
      check("in_ready", {31'd0, in_ready}, 32'd1);
      check("fma_en_hs", {31'd0, fma_en}, 32'd1);
      check("fma_update_acc", {31'd0, fma_update_acc}, {31'd0, upd});
      check("fma_a_pass", fma_a, a);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   initial begin
      // Reset values
      #1;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      check("rst_res_valid", {31'd0, res_valid}, 32'd0);
      check("rst_res_data", res_data, 32'd0);
      check("rst_fma_en", {31'd0, fma_en}, 32'd0);
      check("rst_fma_upd", {31'd0, fma_update_acc}, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);

      // seed=10, len=3 -> 10+6+20-6 = 30
      start_job(32'd10, 3, 1'b1, 32'd30);
      check("busy_run", {31'd0, busy}, 32'd1);
      pair(32'd2, 32'd3, 1'b1);
      pair(32'd4, 32'd5, 1'b0);
      pair(-32'sd1, 32'd6, 1'b0);
      check("t1_res_valid_lat", {31'd0, res_valid}, 32'd1);
      check("t1_in_ready_hold", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      check("t1_idle_busy", {31'd0, busy}, 32'd0);

      // len=0 -> seed echoed, FMA never enabled
      en_seen = 1'b0;
      start_job(-32'sd7, 0, 1'b1, -32'sd7);
      check("t2_hold_valid", {31'd0, res_valid}, 32'd1);
      check("t2_res_data", res_data, -32'sd7);
      @(negedge clk);
      check("t2_fma_en_never", {31'd0, en_seen}, 32'd0);

      // Stalls between pairs -> 1+4 = 5
      start_job(32'd0, 2, 1'b1, 32'd5);
      pair(32'd1, 32'd1, 1'b1);
      repeat (3) begin
         #1 check("t3_stall_fma_en", {31'd0, fma_en}, 32'd0);
         @(negedge clk);
      end
      pair(32'd2, 32'd2, 1'b0);
`ifdef FMA_SEQ_STALL_CNT_EN
      check("t3_stall_cycles", {16'd0, stall_cycles}, 32'd3);
`endif
      @(negedge clk);

      // Result held while start pulses are ignored
      res_ready = 1'b0;
      start_job(32'd5, 1, 1'b1, 32'd11);
      pair(32'd2, 32'd3, 1'b1);
      repeat (4) begin
         start = 1'b1; len = 5'd1; seed = 32'd99;
         #1;
         check("t4_hold_data", res_data, 32'd11);
         check("t4_hold_valid", {31'd0, res_valid}, 32'd1);
         @(negedge clk);
      end
      start = 1'b0;
      res_ready = 1'b1;
      @(negedge clk);
      check("t4_idle_busy", {31'd0, busy}, 32'd0);
      check("t4_idle_valid", {31'd0, res_valid}, 32'd0);

      // Back-to-back jobs: update_acc must reseed
      start_job(32'd100, 1, 1'b1, 32'd109);
      pair(32'd3, 32'd3, 1'b1);
      @(negedge clk);
      start_job(32'd0, 1, 1'b1, 32'd4);
      pair(32'd2, 32'd2, 1'b1);
      @(negedge clk);

      // Async reset mid-RUN after 2 of 4 pairs; no result expected
      start_job(32'd50, 4, 1'b0, 32'd0);
      pair(32'd7, 32'd7, 1'b1);
      pair(32'd8, 32'd8, 1'b0);
      in_valid = 1'b1; in_a = 32'd5; in_b = 32'd5;
      #2 rst_n = 1'b0;
      #1;
      check("t6_rst_busy", {31'd0, busy}, 32'd0);
      check("t6_rst_in_ready", {31'd0, in_ready}, 32'd0);
      check("t6_rst_fma_en", {31'd0, fma_en}, 32'd0);
      check("t6_rst_fma_a", fma_a, 32'd0);
      check("t6_rst_res_valid", {31'd0, res_valid}, 32'd0);
      @(negedge clk);
      in_valid = 1'b0; rst_n = 1'b1;
      @(negedge clk);
      start_job(32'd1, 1, 1'b1, 32'd2);
      pair(32'd1, 32'd1, 1'b1);
      repeat (3) @(negedge clk);

      check("scoreboard_drained", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
